toy_bus_ack_egress_fifo: RTL and testbench



---
 rtl/toy_bus_pkg.sv | 16 +
 rtl/toy_bus_fifo_ctrl.sv | 46 ++++
 rtl/toy_bus_ack_egress_fifo.sv | 96 +++++++++
 tb/tb_toy_bus_ack_egress_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// Shared ToyBus ACK definitions: message layout and default field widths.
package toy_bus_pkg;

    localparam int TOY_BUS_DATA_W = 256;
    localparam int TOY_BUS_SB_W   = 32;
    localparam int TOY_BUS_ID_W   = 4;

    typedef struct packed {
        logic                      opcode;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic [TOY_BUS_SB_W-1:0]   sideband;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_ack_t;

endpackage

// File: rtl/toy_bus_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for the ACK egress FIFO.
module toy_bus_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= {(PTR_W+1){1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/toy_bus_ack_egress_fifo.sv
// ACK egress FIFO between the ACK arbiter and the LSU response port.
// Optional zero-latency empty bypass: define TOY_BUS_ACK_FIFO_BYPASS_EN.
module toy_bus_ack_egress_fifo
    import toy_bus_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = TOY_BUS_DATA_W,
    parameter int SB_W   = TOY_BUS_SB_W,
    parameter int ID_W   = TOY_BUS_ID_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic                     in_opcode,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SB_W-1:0]          in_sideband,
    input  logic [ID_W-1:0]          in_src_id,
    input  logic [ID_W-1:0]          in_tgt_id,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_opcode,
    output logic [DATA_W-1:0]        out_data,
    output logic [SB_W-1:0]          out_sideband,
    output logic [ID_W-1:0]          out_src_id,
    output logic [ID_W-1:0]          out_tgt_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         ack_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 1 + DATA_W + SB_W + 2 * ID_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             deliver;
    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] ram_head;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] mem [DEPTH];

    toy_bus_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign in_ent   = {in_opcode, in_data, in_sideband, in_src_id, in_tgt_id};
    assign ram_head = mem[rd_ptr];
    // in_rdy comes from registered occupancy only, never from out_rdy.
    assign in_rdy   = ~full;

`ifdef TOY_BUS_ACK_FIFO_BYPASS_EN
    logic bypass;
    assign bypass  = empty & in_vld;
    assign out_vld = ~empty | bypass;
    assign head    = bypass ? in_ent : ram_head;
    assign deliver = out_vld & out_rdy;
    assign push    = in_vld & ~full & ~(bypass & out_rdy);
    assign pop     = deliver & ~empty;
`else
    assign out_vld = ~empty;
    assign head    = ram_head;
    assign deliver = out_vld & out_rdy;
    assign push    = in_vld & ~full;
    assign pop     = deliver;
`endif

    assign {out_opcode, out_data, out_sideband, out_src_id, out_tgt_id} = head;

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_ent;
    end

    // Delivered-ACK counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ack_cnt <= {CNT_W{1'b0}};
        end else if (deliver && (ack_cnt != {CNT_W{1'b1}})) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_toy_bus_ack_egress_fifo.sv
// Self-checking bench: directed + random stimulus against a queue model.
module tb_toy_bus_ack_egress_fifo;
    import toy_bus_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_vld, in_opcode, out_rdy;
    logic [255:0] in_data;
    logic [31:0]  in_sideband;
    logic [3:0]   in_src_id, in_tgt_id;

    logic         in_rdy, out_vld, out_opcode, full, empty;
    logic [255:0] out_data;
    logic [31:0]  out_sideband;
    logic [3:0]   out_src_id, out_tgt_id;
    logic [2:0]   count;
    logic [15:0]  ack_cnt;

    logic         b_in_rdy, b_out_vld, b_out_opcode, b_full, b_empty;
    logic [255:0] b_out_data;
    logic [31:0]  b_out_sideband;
    logic [3:0]   b_out_src_id, b_out_tgt_id;
    logic [2:0]   b_count;
    logic [3:0]   b_ack_cnt;

    toy_bus_ack_egress_fifo dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_opcode(in_opcode), .in_data(in_data), .in_sideband(in_sideband),
        .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_opcode(out_opcode), .out_data(out_data),
        .out_sideband(out_sideband), .out_src_id(out_src_id),
        .out_tgt_id(out_tgt_id), .count(count), .full(full), .empty(empty),
        .ack_cnt(ack_cnt)
    );

    // Narrow counter instance to observe saturation.
    toy_bus_ack_egress_fifo #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(b_in_rdy),
        .in_opcode(in_opcode), .in_data(in_data), .in_sideband(in_sideband),
        .in_src_id(in_src_id), .in_tgt_id(in_tgt_id), .out_vld(b_out_vld),
        .out_rdy(out_rdy), .out_opcode(b_out_opcode), .out_data(b_out_data),
        .out_sideband(b_out_sideband), .out_src_id(b_out_src_id),
        .out_tgt_id(b_out_tgt_id), .count(b_count), .full(b_full),
        .empty(b_empty), .ack_cnt(b_ack_cnt)
    );

    always #5 clk = ~clk;

    toy_bus_ack_t q[$];
    int pops;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        pops = 0;
        chk("rst_count", 256'(count), 256'd0);
        chk("rst_empty", 256'(empty), 256'd1);
        chk("rst_full", 256'(full), 256'd0);
        chk("rst_out_vld", 256'(out_vld), 256'd0);
        chk("rst_in_rdy", 256'(in_rdy), 256'd1);
        chk("rst_ack_cnt", 256'(ack_cnt), 256'd0);
        chk("rst_ack_sat", 256'(b_ack_cnt), 256'd0);
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, then update the model.
    task automatic step(input logic v, input logic r, input logic [255:0] d,
                        input logic [3:0] s, input logic [3:0] t);
        int           n;
        logic         byp, exp_vld, do_push, do_pop;
        toy_bus_ack_t cur, hd;
        in_vld = v; out_rdy = r; in_data = d; in_opcode = d[0];
        in_sideband = d[63:32]; in_src_id = s; in_tgt_id = t;
        cur = '{opcode: d[0], data: d, sideband: d[63:32], src_id: s, tgt_id: t};
        @(negedge clk);
        n = q.size();
        byp = 1'b0;
`ifdef TOY_BUS_ACK_FIFO_BYPASS_EN
        byp = (n == 0) && v;
`endif
        exp_vld = (n > 0) || byp;
        chk("out_vld", 256'(out_vld), 256'(exp_vld));
        chk("in_rdy", 256'(in_rdy), 256'(n < 4));
        chk("count", 256'(count), 256'(n));
        chk("full", 256'(full), 256'(n == 4));
        chk("empty", 256'(empty), 256'(n == 0));
        chk("ack_cnt", 256'(ack_cnt), 256'(pops));
        chk("ack_sat", 256'(b_ack_cnt), 256'(pops > 15 ? 15 : pops));
        if (exp_vld) begin
            hd = (n > 0) ? q[0] : cur;
            chk("out_data", out_data, hd.data);
            chk("out_opcode", 256'(out_opcode), 256'(hd.opcode));
            chk("out_sideband", 256'(out_sideband), 256'(hd.sideband));
            chk("out_src_id", 256'(out_src_id), 256'(hd.src_id));
            chk("out_tgt_id", 256'(out_tgt_id), 256'(hd.tgt_id));
        end
        do_pop  = exp_vld && r;
        do_push = v && (n < 4) && !(byp && r);
        @(posedge clk);
        if (do_pop) begin
            pops++;
            if (n > 0) void'(q.pop_front());
        end
        if (do_push) q.push_back(cur);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    initial begin
        logic [255:0] held;
        do_reset();

        // Fill four entries while the sink stalls, then drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 256'(i * 17), 4'(i), 4'(i));
        chk("fill_full", 256'(full), 256'd1);
        chk("fill_in_rdy", 256'(in_rdy), 256'd0);
        chk("fill_count", 256'(count), 256'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", out_data, 256'(i * 17));
            step(1'b0, 1'b1, 256'd0, 4'd0, 4'd0);
        end
        chk("drain_ack_cnt", 256'(ack_cnt), 256'd4);

        // Steady push+pop at count 2 across pointer wraps.
        step(1'b1, 1'b0, rnd256(), 4'd0, 4'd9);
        step(1'b1, 1'b0, rnd256(), 4'd1, 4'd9);
        for (int i = 2; i < 22; i++) begin
            step(1'b1, 1'b1, rnd256(), 4'(i), 4'd9);
            chk("stream_count", 256'(count), 256'd2);
        end

        // Backpressure hold for five cycles.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, rnd256(), 4'd0, 4'd0);
            chk("hold_vld", 256'(out_vld), 256'd1);
            chk("hold_data", out_data, q[0].data);
            chk("hold_tgt", 256'(out_tgt_id), 256'(q[0].tgt_id));
        end

        // Upstream holds a message while full; one pop frees a slot next cycle.
        step(1'b1, 1'b0, rnd256(), 4'd5, 4'd5);
        step(1'b1, 1'b0, rnd256(), 4'd6, 4'd6);
        held = rnd256();
        step(1'b1, 1'b0, held, 4'd7, 4'd7);
        chk("held_in_rdy", 256'(in_rdy), 256'd0);
        step(1'b1, 1'b1, held, 4'd7, 4'd7);
        chk("after_pop_in_rdy", 256'(in_rdy), 256'd1);
        step(1'b1, 1'b0, held, 4'd7, 4'd7);
        chk("held_accepted", q[3].data, held);
        chk("held_count", 256'(count), 256'd4);

        // Drain, then present one message to an empty FIFO with the sink ready.
        for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, 1'b1, 256'd0, 4'd0, 4'd0);
        step(1'b1, 1'b1, 256'hAB, 4'd3, 4'd3);
        in_vld = 1'b0;
        #1;
`ifdef TOY_BUS_ACK_FIFO_BYPASS_EN
        chk("byp_count", 256'(count), 256'd0);
        chk("byp_out_vld", 256'(out_vld), 256'd0);
`else
        chk("nobyp_out_vld", 256'(out_vld), 256'd1);
        chk("nobyp_data", out_data, 256'hAB);
        chk("nobyp_count", 256'(count), 256'd1);
`endif

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rnd256(),
                 4'($urandom), 4'($urandom));
        chk("sat_final", 256'(b_ack_cnt), 256'd15);

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd256(), 4'(i), 4'(i));
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd256(),
                 4'($urandom), 4'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
